uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
// PURPOSE
//  Receive end of the ADC scan UART link. Deserialises the 8N1 byte stream on rx_in,
//  parses head/payload/tail frames, and reassembles 32-bit ADC words tagged with their
//  scan index. Used on the host-side FPGA and as the loopback checker for the scan path.
// PARAMETERS
//  CLKS_PER_BIT  16     clock cycles per UART bit; must be an even integer >= 4
//  HEAD_BYTE     8'hA5  frame start marker
//  TAIL_BYTE     8'h5A  frame end marker
//  WORDS         32     32-bit words per frame; must be <= 2**IDX_W
//  IDX_W         5      width of word_index
// PORTS
//  clock          in   1      system clock (the pll_c0 domain)
//  reset          in   1      asynchronous, active-high
//  rx_in          in   1      UART serial input, idle high, asynchronous to clock
//  rx_byte        out  8      last good byte received
//  rx_byte_valid  out  1      1-cycle pulse when rx_byte updates
//  word_data      out  32     assembled word; first byte received is bits [31:24]
//  word_valid     out  1      1-cycle pulse when word_data/word_index update
//  word_index     out  IDX_W  position of word_data in the frame, 0..WORDS-1
//  frame_done     out  1      1-cycle pulse when a correct tail byte is accepted
//  frame_err      out  1      1-cycle pulse when the current frame is aborted
//  err_count      out  8      saturating count of frame_err pulses
// BEHAVIOUR
//  Reset: all outputs are 0. Both FSMs return to IDLE. The synchroniser is set to 1 (idle).
//  Reset mid-byte or mid-frame discards all partial state. No output pulse is produced.
//  Input synchronisation
//  - rx_in passes through a 2-flop synchroniser. All logic below uses the synchronised value rxs.
//  Bit FSM: IDLE -> START -> DATA -> STOP -> IDLE
//  - IDLE: a 1->0 transition on rxs moves to START and clears the bit counter.
//  - START: resample at CLKS_PER_BIT/2. If rxs=1, treat it as a glitch: return to IDLE with no error.
//    Otherwise move to DATA.
//  - DATA: sample every CLKS_PER_BIT cycles at bit centre. 8 bits are received LSB first.
//  - STOP: sample the stop bit at its centre.
//    - rxs=1: on that same cycle, load rx_byte and pulse rx_byte_valid. Return to IDLE immediately,
//      so a following start edge is detected without losing a bit.
//    - rxs=0 (framing error): drop the byte and raise an internal byte_err. Wait in STOP until rxs=1,
//      then go to IDLE.
//  Frame FSM: F_IDLE -> F_PAYLOAD -> F_TAIL, driven by rx_byte_valid and byte_err
//  - F_IDLE: a byte equal to HEAD_BYTE moves to F_PAYLOAD and clears the byte and word counters.
//    Any other byte is ignored silently. byte_err in F_IDLE is ignored, with no frame_err.
//  - F_PAYLOAD: each byte shifts into a 32-bit accumulator, MSB first.
//    - Marker values are ordinary data here; there is no resync inside the payload.
//    - On the 4th byte: word_data is the accumulator including the current byte, word_index is the
//      word counter, and word_valid pulses. word_valid fires 1 cycle after the rx_byte_valid of the
//      4th byte.
//    - After word WORDS-1, move to F_TAIL.
//  - F_TAIL: TAIL_BYTE pulses frame_done, 1 cycle after its rx_byte_valid, and returns to F_IDLE.
//    Any other byte pulses frame_err and returns to F_IDLE. That byte is not re-examined as a head.
//  - byte_err in F_PAYLOAD or F_TAIL pulses frame_err and returns to F_IDLE.
//    Words already emitted from that frame stand and are not retracted.
//  - err_count increments on each frame_err and saturates at 8'hFF. Only reset clears it.
//  - frame_done and frame_err are mutually exclusive in any cycle.
//  - word_index wraps to 0 at the start of every frame.
//  - word_data holds its value between pulses.
// TESTING
//  1. Send A5, 128 bytes of 00..7F, then 5A at CLKS_PER_BIT=16.
//     -> 32 word_valid pulses; word 0 = 32'h00010203, word 31 = 32'h7C7D7E7F;
//        word_index 0..31; one frame_done; err_count=0.
//  2. Payload bytes all A5/5A, then 5A -> words 32'hA55AA55A and the like are accepted as data;
//     frame_done pulses; no resync occurs.
//  3. Send A5 + 128 bytes, then 33 -> frame_err pulses once; err_count=1; no frame_done.
//     A following good frame completes normally.
//  4. Stop bit forced to 0 on payload byte 6 -> 1 word emitted, then frame_err; err_count=1.
//     Line idle afterwards, then a good frame -> recovers fully.
//  5. A 4-cycle low glitch on rx_in while idle -> no rx_byte_valid and no error.
//     Stray bytes 11, 22 before A5 -> silently ignored.
//  6. Assert reset during byte 70 of a frame -> all outputs 0 immediately.
//     After release, a complete frame yields word_index starting at 0.
//     Separately, 300 bad frames -> err_count saturates at FF.

Source files
------------

// File: rtl/uart_frame_rx_if.sv
// Signal bundle between the UART frame receiver and its consumer: the serial line in,
// plus the byte, word and frame status outputs.
interface uart_frame_rx_if #(
  parameter int IDX_W = 5
);
  logic             rx_in;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic [31:0]      word_data;
  logic             word_valid;
  logic [IDX_W-1:0] word_index;
  logic             frame_done;
  logic             frame_err;
  logic [7:0]       err_count;

  modport master (
    input  rx_in,
    output rx_byte, rx_byte_valid, word_data, word_valid, word_index,
           frame_done, frame_err, err_count
  );

  modport slave (
    output rx_in,
    input  rx_byte, rx_byte_valid, word_data, word_valid, word_index,
           frame_done, frame_err, err_count
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Receive end of the ADC scan UART link: 8N1 deserialiser feeding a head/payload/tail
// frame parser that reassembles 32-bit words tagged with their position in the scan.
module uart_frame_rx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HEAD_BYTE    = 8'hA5,
  parameter logic [7:0] TAIL_BYTE    = 8'h5A,
  parameter int         WORDS        = 32,
  parameter int         IDX_W        = 5
) (
  input  logic               clock,
  input  logic               reset,
  uart_frame_rx_if.master    bus
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
  typedef enum logic [1:0] {F_IDLE, F_PAYLOAD, F_TAIL} frame_state_e;

  // Bit level state
  logic [1:0]       sync_q, sync_d;
  logic             rxs_prev_q, rxs_prev_d;
  bit_state_e       bstate_q, bstate_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_wait_q, stop_wait_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_valid_q, rx_byte_valid_d;
  logic             byte_err_q, byte_err_d;
  logic             rxs;

  // Frame level state
  frame_state_e     fstate_q, fstate_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]      acc_q, acc_d;
  logic [31:0]      word_data_q, word_data_d;
  logic [IDX_W-1:0] word_index_q, word_index_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             abort;

  assign rxs = sync_q[1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    sync_d          = {sync_q[0], bus.rx_in};
    rxs_prev_d      = rxs;
    bstate_d        = bstate_q;
    clk_cnt_d       = clk_cnt_q + 1'b1;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    stop_wait_d     = stop_wait_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    byte_err_d      = 1'b0;
    case (bstate_q)
      B_IDLE: begin
        clk_cnt_d   = '0;
        stop_wait_d = 1'b0;
        if (rxs_prev_q && !rxs) begin
          bstate_d  = B_START;
          bit_cnt_d = '0;
        end
      end
      B_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bstate_d  = rxs ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) bstate_d = B_STOP;
        end
      end
      B_STOP: begin
        if (stop_wait_q) begin
          // Framing error: park here until the line returns high.
          clk_cnt_d = '0;
          if (rxs) bstate_d = B_IDLE;
        end else if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          if (rxs) begin
            rx_byte_d       = shift_q;
            rx_byte_valid_d = 1'b1;
            bstate_d        = B_IDLE;
          end else begin
            byte_err_d  = 1'b1;
            stop_wait_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    fstate_d     = fstate_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    acc_d        = acc_q;
    word_data_d  = word_data_q;
    word_index_d = word_index_q;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    abort        = 1'b0;
    case (fstate_q)
      F_IDLE: begin
        if (rx_byte_valid_q && rx_byte_q == HEAD_BYTE) begin
          fstate_d   = F_PAYLOAD;
          byte_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      F_PAYLOAD: begin
        if (byte_err_q) begin
          abort = 1'b1;
        end else if (rx_byte_valid_q) begin
          acc_d      = {acc_q[15:0], rx_byte_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_data_d  = {acc_q, rx_byte_q};
            word_index_d = word_cnt_q;
            word_valid_d = 1'b1;
            word_cnt_d   = word_cnt_q + IDX_W'(1);
            if (word_cnt_q == LAST_WORD) fstate_d = F_TAIL;
          end
        end
      end
      F_TAIL: begin
        if (byte_err_q) begin
          abort = 1'b1;
        end else if (rx_byte_valid_q) begin
          // A wrong tail is consumed here, never re-examined as a head.
          fstate_d = F_IDLE;
          if (rx_byte_q == TAIL_BYTE) frame_done_d = 1'b1;
          else                        abort        = 1'b1;
        end
      end
      default: fstate_d = F_IDLE;
    endcase
    if (abort) begin
      fstate_d    = F_IDLE;
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q          <= 2'b11;
      rxs_prev_q      <= 1'b1;
      bstate_q        <= B_IDLE;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      stop_wait_q     <= 1'b0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      byte_err_q      <= 1'b0;
      fstate_q        <= F_IDLE;
      byte_cnt_q      <= '0;
      word_cnt_q      <= '0;
      acc_q           <= '0;
      word_data_q     <= '0;
      word_index_q    <= '0;
      word_valid_q    <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      err_count_q     <= '0;
    end else begin
      sync_q          <= sync_d;
      rxs_prev_q      <= rxs_prev_d;
      bstate_q        <= bstate_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      stop_wait_q     <= stop_wait_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      byte_err_q      <= byte_err_d;
      fstate_q        <= fstate_d;
      byte_cnt_q      <= byte_cnt_d;
      word_cnt_q      <= word_cnt_d;
      acc_q           <= acc_d;
      word_data_q     <= word_data_d;
      word_index_q    <= word_index_d;
      word_valid_q    <= word_valid_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
      err_count_q     <= err_count_d;
    end
  end

  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_byte_valid = rx_byte_valid_q;
  assign bus.word_data     = word_data_q;
  assign bus.word_valid    = word_valid_q;
  assign bus.word_index    = word_index_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good, marker-heavy, bad-tail, framing-error,
// glitch/stray-byte, mid-frame reset and error-counter saturation scenarios.
module tb_uart_frame_rx;

  localparam int CPB = 4;

  logic clock;
  logic reset;

  uart_frame_rx_if #(.IDX_W(5)) bus ();

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .HEAD_BYTE   (8'hA5),
    .TAIL_BYTE   (8'h5A),
    .WORDS       (32),
    .IDX_W       (5)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] words[$];
  logic [31:0] idxs[$];
  int          n_done = 0;
  int          n_ferr = 0;
  int          n_rbv  = 0;
  logic        prev_rbv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge away from the active edge.
  always @(negedge clock) begin
    if (bus.word_valid) begin
      words.push_back(bus.word_data);
      idxs.push_back(32'(bus.word_index));
      check("word_valid_latency", 32'(prev_rbv), 32'd1);
    end
    if (bus.frame_done || bus.frame_err)
      check("done_err_exclusive", 32'(bus.frame_done & bus.frame_err), 32'd0);
    if (bus.frame_done)    n_done++;
    if (bus.frame_err)     n_ferr++;
    if (bus.rx_byte_valid) n_rbv++;
    prev_rbv = bus.rx_byte_valid;
  end

  task automatic clear_mon();
    words.delete();
    idxs.delete();
    n_done = 0;
    n_ferr = 0;
    n_rbv  = 0;
  endtask

  task automatic idle_bits(input int n);
    bus.rx_in = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bus.rx_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    bus.rx_in = stop_ok;
    repeat (CPB) @(negedge clock);
    if (!stop_ok) idle_bits(1);
  endtask

  function automatic logic [7:0] pay(input int kind, input int i);
    if (kind == 0) return 8'(i);
    return (i % 2 == 0) ? 8'hA5 : 8'h5A;
  endfunction

  task automatic send_frame(input int kind, input logic [7:0] tail);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 128; i++) send_byte(pay(kind, i), 1'b1);
    send_byte(tail, 1'b1);
    idle_bits(2);
  endtask

  task automatic apply_reset();
    bus.rx_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic check_good_frame(input string tag, input int kind);
    logic [31:0] e;
    check({tag, "_nwords"}, 32'(words.size()), 32'd32);
    check({tag, "_done"}, 32'(n_done), 32'd1);
    check({tag, "_ferr"}, 32'(n_ferr), 32'd0);
    for (int k = 0; k < 32; k++) begin
      if (kind == 0) e = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
      else           e = 32'hA55AA55A;
      check({tag, "_word"}, words[k], e);
      check({tag, "_index"}, idxs[k], 32'(k));
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.rx_in = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_rx_byte", 32'(bus.rx_byte), 32'd0);
    check("rst_rx_byte_valid", 32'(bus.rx_byte_valid), 32'd0);
    check("rst_word_data", bus.word_data, 32'd0);
    check("rst_word_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word_index", 32'(bus.word_index), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // 1: counting payload
    clear_mon();
    send_frame(0, 8'h5A);
    check_good_frame("t1", 0);
    check("t1_rbv", 32'(n_rbv), 32'd130);
    check("t1_err_count", 32'(bus.err_count), 32'd0);

    // 2: payload made only of marker values
    clear_mon();
    send_frame(1, 8'h5A);
    check_good_frame("t2", 1);
    check("t2_rx_byte", 32'(bus.rx_byte), 32'h5A);

    // 3: wrong tail, then a good frame
    clear_mon();
    send_frame(0, 8'h33);
    check("t3_nwords", 32'(words.size()), 32'd32);
    check("t3_ferr", 32'(n_ferr), 32'd1);
    check("t3_done", 32'(n_done), 32'd0);
    check("t3_err_count", 32'(bus.err_count), 32'd1);
    clear_mon();
    send_frame(0, 8'h5A);
    check_good_frame("t3b", 0);
    check("t3b_err_count", 32'(bus.err_count), 32'd1);

    // 4: bad stop bit on payload byte 6
    apply_reset();
    clear_mon();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h05, 1'b0);
    idle_bits(3);
    check("t4_nwords", 32'(words.size()), 32'd1);
    check("t4_word0", words[0], 32'h00010203);
    check("t4_ferr", 32'(n_ferr), 32'd1);
    check("t4_done", 32'(n_done), 32'd0);
    check("t4_err_count", 32'(bus.err_count), 32'd1);
    clear_mon();
    send_frame(0, 8'h5A);
    check_good_frame("t4b", 0);
    check("t4b_err_count", 32'(bus.err_count), 32'd1);

    // 5: short low glitch (under half a bit), then stray bytes ahead of a frame
    clear_mon();
    bus.rx_in = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clock);
    idle_bits(12);
    check("t5_glitch_rbv", 32'(n_rbv), 32'd0);
    check("t5_glitch_ferr", 32'(n_ferr), 32'd0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle_bits(2);
    check("t5_stray_rbv", 32'(n_rbv), 32'd2);
    check("t5_stray_rx_byte", 32'(bus.rx_byte), 32'h22);
    check("t5_stray_words", 32'(words.size()), 32'd0);
    check("t5_stray_ferr", 32'(n_ferr), 32'd0);
    clear_mon();
    send_frame(0, 8'h5A);
    check_good_frame("t5", 0);

    // 6: reset in the middle of payload byte 70
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 69; i++) send_byte(8'(i + 8'h40), 1'b1);
    bus.rx_in = 1'b0;
    repeat (2 * CPB) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_word_data", bus.word_data, 32'd0);
    check("t6_rst_word_index", 32'(bus.word_index), 32'd0);
    check("t6_rst_err_count", 32'(bus.err_count), 32'd0);
    check("t6_rst_rx_byte", 32'(bus.rx_byte), 32'd0);
    @(negedge clock);
    bus.rx_in = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    idle_bits(2);
    clear_mon();
    send_frame(0, 8'h5A);
    check_good_frame("t6", 0);

    // Error counter saturation over 300 aborted frames
    clear_mon();
    for (int i = 0; i < 254; i++) begin
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b0);
    end
    idle_bits(2);
    check("sat_254", 32'(bus.err_count), 32'hFE);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b0);
    idle_bits(2);
    check("sat_255", 32'(bus.err_count), 32'hFF);
    for (int i = 0; i < 45; i++) begin
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b0);
    end
    idle_bits(2);
    check("sat_300", 32'(bus.err_count), 32'hFF);
    check("sat_ferr_pulses", 32'(n_ferr), 32'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
